axi_lite_sram: RTL

AXI4-Lite slave SRAM model that terminates the arbiter's s0 port in the SoC top, on the sram_* AR/R/AW/W/B signals.
- Word-addressed memory array; byte-strobe writes.
- Independent read and write channel FSMs.
- Programmable response latency, fixed or LFSR-random, to stress the fetch and LSU handshakes.

---
 rtl/axi_lite_sram_pkg.sv | 30 +++
 rtl/axi_lite_sram_delay_lfsr.sv | 24 ++
 rtl/axi_lite_sram.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_pkg.sv
// Shared AXI-Lite bus macros and helpers for the axi_lite_sram slave model.
// The macros are guarded so any other file that defines them can coexist.
`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ADDR_BUS [31:0]
`define AXI_DATA_BUS [31:0]
`define AXI_WSTRB_BUS [3:0]
`define AXI_RESP_BUS [1:0]
`define AXI_RESP_OKAY 2'b00
`define AXI_RESP_DECERR 2'b11
`endif

package axi_lite_sram_pkg;

    // Right-shift Galois toggle mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_sram_delay_lfsr.sv
// Free-running 8-bit Galois LFSR used to randomise the SRAM response latency.
module delay_lfsr
    import axi_lite_sram_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_q
);

    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]};
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave SRAM with byte-strobe writes, independent read/write FSMs and
// fixed or LFSR-random response latency.
module axi_lite_sram
    import axi_lite_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter bit          RAND_DELAY  = 1'b0,
    parameter int unsigned FIXED_DELAY = 1,
    parameter logic [7:0]  DELAY_MASK  = 8'h07,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic `AXI_ADDR_BUS   sram_araddr,
    input  logic                 sram_arvalid,
    output logic                 sram_arready,
    output logic `AXI_DATA_BUS   sram_rdata,
    output logic `AXI_RESP_BUS   sram_rresp,
    output logic                 sram_rvalid,
    input  logic                 sram_rready,
    input  logic `AXI_ADDR_BUS   sram_awaddr,
    input  logic                 sram_awvalid,
    output logic                 sram_awready,
    input  logic `AXI_DATA_BUS   sram_wdata,
    input  logic `AXI_WSTRB_BUS  sram_wstrb,
    input  logic                 sram_wvalid,
    output logic                 sram_wready,
    output logic `AXI_RESP_BUS   sram_bresp,
    output logic                 sram_bvalid,
    input  logic                 sram_bready
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(WORD_BYTES * DEPTH_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    logic [31:0] mem [DEPTH_WORDS];

    logic        init_q;
    logic [7:0]  lfsr;
    logic [7:0]  delay_val;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        r_capture;
    logic [31:0] rd_addr, rd_off;
    logic        rd_hit;
    logic [IDX_W-1:0] rd_idx;

    w_state_e    w_state_q, w_state_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_hs, w_hs, commit, mem_we;
    logic [31:0] wr_addr, wr_off, wr_data;
    logic [3:0]  wr_strb;
    logic        wr_hit;
    logic [IDX_W-1:0] wr_idx;

    delay_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_q (lfsr)
    );

    assign delay_val = RAND_DELAY ? (lfsr & DELAY_MASK) : 8'(FIXED_DELAY);

    // Offsets below the base wrap to huge values, so one compare covers both bounds
    assign rd_addr = (r_state_q == R_IDLE) ? sram_araddr : raddr_q;
    assign rd_off  = rd_addr - ADDR_BASE;
    assign rd_hit  = rd_off < SPAN;
    assign rd_idx  = rd_off[IDX_W+1:2];

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        r_capture = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (sram_arvalid && init_q) begin
                    raddr_d = sram_araddr;
                    rcnt_d  = delay_val;
                    if (delay_val == 8'd0) begin
                        r_capture = 1'b1;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rcnt_q == 8'd1) begin
                    r_capture = 1'b1;
                    r_state_d = R_RESP;
                end else begin
                    rcnt_d = rcnt_q - 8'd1;
                end
            end
            R_RESP: begin
                if (sram_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (r_capture) begin
            rdata_d = rd_hit ? mem[rd_idx] : 32'd0;
            rresp_d = rd_hit ? `AXI_RESP_OKAY : `AXI_RESP_DECERR;
        end
    end

    // Until a channel is latched the live bus supplies address/data to the commit path
    assign aw_hs   = (w_state_q == W_IDLE) && init_q && !aw_done_q && sram_awvalid;
    assign w_hs    = (w_state_q == W_IDLE) && init_q && !w_done_q && sram_wvalid;
    assign wr_addr = aw_done_q ? awaddr_q : sram_awaddr;
    assign wr_data = w_done_q ? wdata_q : sram_wdata;
    assign wr_strb = w_done_q ? wstrb_q : sram_wstrb;
    assign wr_off  = wr_addr - ADDR_BASE;
    assign wr_hit  = wr_off < SPAN;
    assign wr_idx  = wr_off[IDX_W+1:2];

    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wcnt_d    = wcnt_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = sram_awaddr;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = sram_wdata;
                    wstrb_d  = sram_wstrb;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    wcnt_d = delay_val;
                    if (delay_val == 8'd0) begin
                        commit    = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wcnt_q == 8'd1) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (sram_bready) begin
                    w_state_d = W_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        bresp_d = bresp_q;
        if (commit) bresp_d = wr_hit ? `AXI_RESP_OKAY : `AXI_RESP_DECERR;
        mem_we = commit && wr_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wcnt_q    <= '0;
            bresp_q   <= '0;
        end else begin
            init_q    <= 1'b1;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wcnt_q    <= wcnt_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory contents survive reset; a read captured in the commit cycle sees old data
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= merge_wstrb(mem[wr_idx], wr_data, wr_strb);
    end

    assign sram_arready = init_q && (r_state_q == R_IDLE);
    assign sram_rvalid  = (r_state_q == R_RESP);
    assign sram_rdata   = rdata_q;
    assign sram_rresp   = rresp_q;
    assign sram_awready = init_q && (w_state_q == W_IDLE) && !aw_done_q;
    assign sram_wready  = init_q && (w_state_q == W_IDLE) && !w_done_q;
    assign sram_bvalid  = (w_state_q == W_RESP);
    assign sram_bresp   = bresp_q;

endmodule
